// File: rtl/flash_phy_rd_buf_sched.sv
// flash_phy_rd_buf_sched
//   Allocation/replacement scheduler for the flash phy read-buffer array.
//   Looks up each read request against the buffer tags and reports a hit or
//   allocates a victim buffer. It tracks outstanding flash reads in order,
//   steers each read response to the buffer that owns it, and wipes matching
//   buffers on program requests.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   en_i                         buffering enable (low = bypass, no alloc/hit)
//   req_valid_i/req_ready_o      read request handshake, req_tag_i tag
//   hit_o, hit_idx_o             accepted request hit a Valid buffer
//   rd_req_o                     issue flash read for an accepted miss
//   prog_valid_i/prog_ready_o    program handshake, prog_tag_i tag
//   rsp_valid_i                  in-order flash read return, no backpressure
//   buf_valid_i/buf_wip_i        per-buffer attribute status
//   buf_tag_i                    per-buffer tag, buffer i at [i*TagW +: TagW]
//   alloc_o/update_o             one-hot buffer commands
//   wipe_o                       multi-hot wipe command
//   rsp_unexp_o                  sticky flag: response arrived with nothing outstanding
//
// Optional feature: define FLASH_RD_BUF_SCHED_PERF_CNT_EN to add the
// saturating hit_cnt_o / miss_cnt_o performance counters.

module flash_phy_rd_buf_sched #(
  parameter int unsigned NumBuf   = 4,
  parameter int unsigned TagW     = 22,
  parameter int unsigned RspDepth = 4,
  localparam int unsigned IdxW    = $clog2(NumBuf),
  localparam int unsigned PtrW    = (RspDepth > 1) ? $clog2(RspDepth) : 1,
  localparam int unsigned CntW    = $clog2(RspDepth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [TagW-1:0]        req_tag_i,
  output logic                   hit_o,
  output logic [IdxW-1:0]        hit_idx_o,
  output logic                   rd_req_o,
  input  logic                   prog_valid_i,
  output logic                   prog_ready_o,
  input  logic [TagW-1:0]        prog_tag_i,
  input  logic                   rsp_valid_i,
  input  logic [NumBuf-1:0]      buf_valid_i,
  input  logic [NumBuf-1:0]      buf_wip_i,
  input  logic [NumBuf*TagW-1:0] buf_tag_i,
  output logic [NumBuf-1:0]      alloc_o,
  output logic [NumBuf-1:0]      update_o,
  output logic [NumBuf-1:0]      wipe_o,
`ifdef FLASH_RD_BUF_SCHED_PERF_CNT_EN
  output logic [15:0]            hit_cnt_o,
  output logic [15:0]            miss_cnt_o,
`endif
  output logic                   rsp_unexp_o
);

  // Tag lookup
  logic [NumBuf-1:0] req_eq, prog_eq;
  logic [NumBuf-1:0] match_req, wip_req, match_prog, wip_prog;

  always_comb begin
    req_eq  = '0;
    prog_eq = '0;
    for (int unsigned i = 0; i < NumBuf; i++) begin
      req_eq[i]  = (buf_tag_i[i*TagW +: TagW] == req_tag_i);
      prog_eq[i] = (buf_tag_i[i*TagW +: TagW] == prog_tag_i);
    end
  end

  assign match_req  = req_eq  & buf_valid_i;
  assign wip_req    = req_eq  & buf_wip_i;
  assign match_prog = prog_eq & buf_valid_i;
  assign wip_prog   = prog_eq & buf_wip_i;

  // Outstanding-read FIFO state
  logic [IdxW-1:0] fifo_idx   [RspDepth];
  logic            fifo_nobuf [RspDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] rr_q;

  logic fifo_empty, fifo_full, pop, room;
  logic push, push_nobuf;
  logic [IdxW-1:0] push_idx;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(RspDepth));
  assign pop        = rsp_valid_i & ~fifo_empty & ~rst_i;
  // A same-cycle pop frees the slot the push needs, so full does not block.
  assign room       = ~fifo_full | pop;

  // Hit index: lowest matching Valid buffer
  logic            hit_any;
  logic [IdxW-1:0] hit_idx_c;

  always_comb begin
    hit_any   = 1'b0;
    hit_idx_c = '0;
    for (int unsigned i = 0; i < NumBuf; i++) begin
      if (!hit_any && match_req[i]) begin
        hit_any   = 1'b1;
        hit_idx_c = IdxW'(i);
      end
    end
  end

  // Victim: lowest free buffer first, otherwise round-robin over non-Wip ones
  logic [NumBuf-1:0] free_buf;
  logic              victim_found;
  logic [IdxW-1:0]   victim;
  int unsigned       rr_j;

  assign free_buf = ~(buf_valid_i | buf_wip_i);

  always_comb begin
    victim_found = 1'b0;
    victim       = '0;
    rr_j         = 0;
    for (int unsigned i = 0; i < NumBuf; i++) begin
      if (!victim_found && free_buf[i]) begin
        victim_found = 1'b1;
        victim       = IdxW'(i);
      end
    end
    for (int unsigned k = 0; k < NumBuf; k++) begin
      rr_j = (32'(rr_q) + k) % NumBuf;
      if (!victim_found && !buf_wip_i[IdxW'(rr_j)]) begin
        victim_found = 1'b1;
        victim       = IdxW'(rr_j);
      end
    end
  end

  // Command generation
  logic prog_rdy;

  always_comb begin
    req_ready_o  = 1'b0;
    hit_o        = 1'b0;
    hit_idx_o    = '0;
    rd_req_o     = 1'b0;
    prog_ready_o = 1'b0;
    alloc_o      = '0;
    update_o     = '0;
    wipe_o       = '0;
    push         = 1'b0;
    push_idx     = '0;
    push_nobuf   = 1'b0;
    prog_rdy     = 1'b0;
    if (!rst_i) begin
      // A Wip buffer is never wiped: its pending update would be orphaned.
      prog_rdy     = en_i ? ~|wip_prog : 1'b1;
      prog_ready_o = prog_rdy;
      if (prog_valid_i && prog_rdy && en_i) begin
        wipe_o = match_prog;
      end
      if (!prog_valid_i) begin
        if (en_i) begin
          if (!(|wip_req)) begin
            if (hit_any) begin
              req_ready_o = 1'b1;
              if (req_valid_i) begin
                hit_o     = 1'b1;
                hit_idx_o = hit_idx_c;
              end
            end else if (victim_found && room) begin
              req_ready_o = 1'b1;
              if (req_valid_i) begin
                alloc_o[victim] = 1'b1;
                rd_req_o        = 1'b1;
                push            = 1'b1;
                push_idx        = victim;
              end
            end
          end
        end else begin
          req_ready_o = room;
          if (req_valid_i && room) begin
            rd_req_o   = 1'b1;
            push       = 1'b1;
            push_nobuf = 1'b1;
          end
        end
      end
      if (pop && en_i && !fifo_nobuf[rd_ptr_q]) begin
        update_o[fifo_idx[rd_ptr_q]] = 1'b1;
      end
    end
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx[wr_ptr_q]   <= push_idx;
      fifo_nobuf[wr_ptr_q] <= push_nobuf;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rr_q        <= '0;
      rsp_unexp_o <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      if (rsp_valid_i && fifo_empty) rsp_unexp_o <= 1'b1;
      if (|alloc_o) begin
        rr_q <= (victim == IdxW'(NumBuf - 1)) ? '0 : victim + 1'b1;
      end
    end
  end

`ifdef FLASH_RD_BUF_SCHED_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_o && hit_cnt_o != '1)       hit_cnt_o  <= hit_cnt_o + 1'b1;
      if ((|alloc_o) && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

  a_alloc_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(alloc_o));
  a_update_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(update_o));
  a_update_to_wip: assert property (@(posedge clk_i) disable iff (rst_i)
    (update_o & ~buf_wip_i) == '0);
  a_no_alloc_wip: assert property (@(posedge clk_i) disable iff (rst_i)
    (alloc_o & buf_wip_i) == '0);

endmodule
